// File: rtl/xgmii_tx_arbiter_if.sv
// Bundle of the two source ports and the shared XGMII transmit port.
// master = frame sources / downstream sink side, slave = the arbiter.
interface xgmii_tx_arbiter_if;
  logic        req0;
  logic        req1;
  logic        gnt0;
  logic        gnt1;
  logic [7:0]  in0_txc;
  logic [63:0] in0_txd;
  logic [7:0]  in1_txc;
  logic [63:0] in1_txd;
  logic [7:0]  xgmii_txc;
  logic [63:0] xgmii_txd;
  logic        frame_done;
  logic        frame_abort;
  logic        frame_port;

  modport master (
    output req0, req1, in0_txc, in0_txd, in1_txc, in1_txd,
    input  gnt0, gnt1, xgmii_txc, xgmii_txd, frame_done, frame_abort, frame_port
  );

  modport slave (
    input  req0, req1, in0_txc, in0_txd, in1_txc, in1_txd,
    output gnt0, gnt1, xgmii_txc, xgmii_txd, frame_done, frame_abort, frame_port
  );
endinterface

// File: rtl/xgmii_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one 64-bit XGMII TX port between
// two sources, with start timeout, overlength/broken-frame abort and forced IFG.
module xgmii_tx_arbiter #(
  parameter int unsigned IFG_WORDS     = 2,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned MAX_WORDS     = 1200
) (
  input logic               xgmii_clk,
  input logic               sys_rst,
  xgmii_tx_arbiter_if.slave bus
);

  localparam logic [7:0]  IDLE_C  = 8'hff;
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [63:0] START_D = 64'hd5555555555555fb;
  localparam logic [7:0]  ERR_C   = 8'hff;
  localparam logic [63:0] ERR_D   = 64'hfefefefefefefefe;

  localparam logic [7:0]  TIMER_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [15:0] WCNT_MAX   = 16'(MAX_WORDS);
  localparam logic [3:0]  IFG_LOAD   = 4'(IFG_WORDS - 1);

  typedef enum logic [1:0] {S_ARB, S_WAIT, S_SEND, S_IFG} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [7:0]  txc_q, txc_d;
  logic [63:0] txd_q, txd_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        port_q, port_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  ifg_q, ifg_d;

  logic [7:0]  cur_txc;
  logic [63:0] cur_txd;
  logic        cur_req;
  logic        cur_term;
  logic        cur_start;

  // Only the selected source is ever looked at; the other is ignored entirely.
  always_comb begin
    cur_txc   = sel_q ? bus.in1_txc : bus.in0_txc;
    cur_txd   = sel_q ? bus.in1_txd : bus.in0_txd;
    cur_req   = sel_q ? bus.req1 : bus.req0;
    cur_start = (cur_txc == START_C) && (cur_txd == START_D);
    cur_term  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (cur_txc[i] && (cur_txd[8*i +: 8] == 8'hfd)) cur_term = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    txc_d   = IDLE_C;
    txd_d   = IDLE_D;
    done_d  = 1'b0;
    abort_d = 1'b0;
    port_d  = port_q;
    timer_d = timer_q;
    wcnt_d  = wcnt_q;
    ifg_d   = ifg_q;

    case (state_q)
      S_ARB: begin
        if (bus.req0 || bus.req1) begin
          sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          last_d  = sel_d;
          gnt0_d  = ~sel_d;
          gnt1_d  = sel_d;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cur_start) begin
          txc_d   = cur_txc;
          txd_d   = cur_txd;
          wcnt_d  = 16'd1;
          state_d = S_SEND;
        end else if (!cur_req) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = S_ARB;
        end else if (timer_q == TIMER_LAST) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          abort_d = 1'b1;
          port_d  = sel_q;
          ifg_d   = IFG_LOAD;
          state_d = S_IFG;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_SEND: begin
        // Terminate is tested first so it wins over the overlength limit.
        if (cur_term) begin
          txc_d   = cur_txc;
          txd_d   = cur_txd;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          done_d  = 1'b1;
          port_d  = sel_q;
          ifg_d   = IFG_LOAD;
          state_d = S_IFG;
        end else if ((cur_txc == 8'hff) || (wcnt_q >= WCNT_MAX)) begin
          txc_d   = ERR_C;
          txd_d   = ERR_D;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          abort_d = 1'b1;
          port_d  = sel_q;
          ifg_d   = IFG_LOAD;
          state_d = S_IFG;
        end else begin
          txc_d = cur_txc;
          txd_d = cur_txd;
          if (wcnt_q != '1) wcnt_d = wcnt_q + 16'd1;
        end
      end

      S_IFG: begin
        if (ifg_q == '0) state_d = S_ARB;
        else             ifg_d   = ifg_q - 4'd1;
      end

      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state_q <= S_ARB;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      txc_q   <= IDLE_C;
      txd_q   <= IDLE_D;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      port_q  <= 1'b0;
      timer_q <= '0;
      wcnt_q  <= '0;
      ifg_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      txc_q   <= txc_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      port_q  <= port_d;
      timer_q <= timer_d;
      wcnt_q  <= wcnt_d;
      ifg_q   <= ifg_d;
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.xgmii_txc   = txc_q;
  assign bus.xgmii_txd   = txd_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.frame_port  = port_q;

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench for xgmii_tx_arbiter (MAX_WORDS reduced to 4 so overlength
// and terminate-vs-overlength priority are reachable in a few cycles).
module tb_xgmii_tx_arbiter;

  localparam logic [7:0]  IDLE_C  = 8'hff;
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [63:0] START_D = 64'hd5555555555555fb;
  localparam logic [7:0]  ERR_C   = 8'hff;
  localparam logic [63:0] ERR_D   = 64'hfefefefefefefefe;
  localparam logic [7:0]  JUNK_C  = 8'h00;
  localparam logic [63:0] JUNK_D  = 64'hdeadbeefcafef00d;
  // Terminate in lane 4 with lanes 4..7 as control.
  localparam logic [7:0]  TERM1_C = 8'hf0;
  localparam logic [63:0] TERM1_D = 64'h070707fd44332211;
  // Terminate in lane 0 of an all-control word.
  localparam logic [7:0]  TERM2_C = 8'hff;
  localparam logic [63:0] TERM2_D = 64'h07070707070707fd;

  logic clk = 1'b0;
  logic sys_rst;
  int   nchk = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  xgmii_tx_arbiter_if bus ();

  xgmii_tx_arbiter #(.IFG_WORDS(2), .START_TIMEOUT(16), .MAX_WORDS(4)) dut (
    .xgmii_clk (clk),
    .sys_rst   (sys_rst),
    .bus       (bus)
  );

  function automatic logic [63:0] dword(input int n);
    return 64'h0102030405060700 + 64'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] c, input logic [63:0] d);
    chk(tag, {bus.xgmii_txc, bus.xgmii_txd}, {c, d});
  endtask

  // Order: gnt0, gnt1, frame_done, frame_abort
  task automatic chk_ctl(input string tag, input bit g0, input bit g1, input bit dn, input bit ab);
    chk(tag, 72'({bus.gnt0, bus.gnt1, bus.frame_done, bus.frame_abort}), 72'({g0, g1, dn, ab}));
  endtask

  task automatic chk_port(input string tag, input bit p);
    chk(tag, 72'(bus.frame_port), 72'(p));
  endtask

  // Non-selected source always presents junk so mis-steering shows up.
  task automatic drive(input bit src, input logic [7:0] c, input logic [63:0] d);
    if (src) begin
      bus.in1_txc = c;      bus.in1_txd = d;
      bus.in0_txc = JUNK_C; bus.in0_txd = JUNK_D;
    end else begin
      bus.in0_txc = c;      bus.in0_txd = d;
      bus.in1_txc = JUNK_C; bus.in1_txd = JUNK_D;
    end
  endtask

  initial begin
    bit src;
    sys_rst  = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.in0_txc = IDLE_C; bus.in0_txd = IDLE_D;
    bus.in1_txc = IDLE_C; bus.in1_txd = IDLE_D;
    step();
    step();

    // Reset state
    chk_word("rst_out", IDLE_C, IDLE_D);
    chk_ctl("rst_ctl", 0, 0, 0, 0);
    chk_port("rst_port", 0);

    // Single frame from source 0, terminate in lane 4 on word 5 (== MAX_WORDS+1)
    sys_rst  = 1'b0;
    bus.req0 = 1'b1;
    step();
    chk_ctl("t1_gnt", 1, 0, 0, 0);
    chk_word("t1_gnt_out", IDLE_C, IDLE_D);
    drive(0, START_C, START_D);
    step();
    chk_word("t1_start", START_C, START_D);
    chk_ctl("t1_start_ctl", 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 8'h00, dword(i));
      step();
      chk_word("t1_data", 8'h00, dword(i));
      chk_ctl("t1_data_ctl", 1, 0, 0, 0);
    end
    drive(0, TERM1_C, TERM1_D);
    step();
    chk_word("t1_term", TERM1_C, TERM1_D);
    chk_ctl("t1_done", 0, 0, 1, 0);
    chk_port("t1_port", 0);
    bus.req0 = 1'b0;
    drive(0, IDLE_C, IDLE_D);
    step();
    chk_word("t1_ifg0", IDLE_C, IDLE_D);
    chk_ctl("t1_ifg0_ctl", 0, 0, 0, 0);
    step();
    chk_word("t1_ifg1", IDLE_C, IDLE_D);
    chk_ctl("t1_ifg1_ctl", 0, 0, 0, 0);

    // Both sources request across three frames: order 0,1,0
    sys_rst = 1'b1;
    step();
    sys_rst  = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      src = 1'(f % 2);
      step();
      chk_ctl("t2_gnt", !src, src, 0, 0);
      chk_word("t2_gnt_out", IDLE_C, IDLE_D);
      drive(src, START_C, START_D);
      step();
      chk_word("t2_start", START_C, START_D);
      chk_ctl("t2_start_ctl", !src, src, 0, 0);
      drive(src, 8'h00, dword(10 + f));
      step();
      chk_word("t2_data", 8'h00, dword(10 + f));
      drive(src, TERM2_C, TERM2_D);
      step();
      chk_word("t2_term", TERM2_C, TERM2_D);
      chk_ctl("t2_done", 0, 0, 1, 0);
      chk_port("t2_port", src);
      drive(src, IDLE_C, IDLE_D);
      step();
      chk_word("t2_ifg0", IDLE_C, IDLE_D);
      chk_ctl("t2_ifg0_ctl", 0, 0, 0, 0);
      step();
      chk_word("t2_ifg1", IDLE_C, IDLE_D);
      chk_ctl("t2_ifg1_ctl", 0, 0, 0, 0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Source 1 never starts: abort on the 16th WAIT cycle
    bus.req1 = 1'b1;
    drive(1, IDLE_C, IDLE_D);
    step();
    chk_ctl("t3_gnt", 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk_ctl("t3_wait", 0, 1, 0, 0);
      chk_word("t3_wait_out", IDLE_C, IDLE_D);
    end
    step();
    chk_ctl("t3_abort", 0, 0, 0, 1);
    chk_port("t3_port", 1);
    chk_word("t3_abort_out", IDLE_C, IDLE_D);
    bus.req1 = 1'b0;
    step();
    chk_ctl("t3_ifg0", 0, 0, 0, 0);
    chk_word("t3_ifg0_out", IDLE_C, IDLE_D);
    step();
    chk_ctl("t3_ifg1", 0, 0, 0, 0);

    // Overlength: START + 3 data forwarded, 4th data replaced by ERROR
    bus.req0 = 1'b1;
    step();
    chk_ctl("t4_gnt", 1, 0, 0, 0);
    drive(0, START_C, START_D);
    step();
    chk_word("t4_start", START_C, START_D);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 8'h00, dword(20 + i));
      step();
      chk_word("t4_data", 8'h00, dword(20 + i));
    end
    drive(0, 8'h00, dword(24));
    step();
    chk_word("t4_err", ERR_C, ERR_D);
    chk_ctl("t4_abort", 0, 0, 0, 1);
    chk_port("t4_port", 0);
    bus.req0 = 1'b0;
    drive(0, 8'h00, dword(25));
    step();
    chk_word("t4_ifg0", IDLE_C, IDLE_D);
    chk_ctl("t4_ifg0_ctl", 0, 0, 0, 0);
    drive(0, 8'h00, dword(26));
    step();
    chk_word("t4_ifg1", IDLE_C, IDLE_D);
    drive(0, IDLE_C, IDLE_D);

    // All-control word mid-frame replaced by ERROR
    bus.req0 = 1'b1;
    step();
    chk_ctl("t5_gnt", 1, 0, 0, 0);
    drive(0, START_C, START_D);
    step();
    chk_word("t5_start", START_C, START_D);
    drive(0, 8'h00, dword(30));
    step();
    chk_word("t5_data", 8'h00, dword(30));
    drive(0, 8'hff, 64'h0707070707070707);
    step();
    chk_word("t5_err", ERR_C, ERR_D);
    chk_ctl("t5_abort", 0, 0, 0, 1);
    chk_port("t5_port", 0);
    bus.req0 = 1'b0;
    drive(0, IDLE_C, IDLE_D);
    step();
    chk_word("t5_ifg0", IDLE_C, IDLE_D);
    chk_ctl("t5_ifg0_ctl", 0, 0, 0, 0);
    step();
    chk_word("t5_ifg1", IDLE_C, IDLE_D);
    chk_ctl("t5_ifg1_ctl", 0, 0, 0, 0);

    // Reset during SEND; afterwards source 0 must win a contested arbitration
    bus.req0 = 1'b1;
    step();
    chk_ctl("t6_gnt", 1, 0, 0, 0);
    drive(0, START_C, START_D);
    step();
    chk_word("t6_start", START_C, START_D);
    drive(0, 8'h00, dword(40));
    step();
    chk_word("t6_data", 8'h00, dword(40));
    sys_rst = 1'b1;
    drive(0, 8'h00, dword(41));
    step();
    chk_word("t6_rst_out", IDLE_C, IDLE_D);
    chk_ctl("t6_rst_ctl", 0, 0, 0, 0);
    sys_rst  = 1'b0;
    bus.req1 = 1'b1;
    drive(0, IDLE_C, IDLE_D);
    step();
    chk_ctl("t6_first_arb", 1, 0, 0, 0);
    chk_word("t6_first_out", IDLE_C, IDLE_D);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
